// File: rtl/stack_controller_if.sv
// rtl/stack_controller_if.sv - operation, SP mirror and memory port bundle for stack_controller
//
// master: CPU/memory side (drives op requests and memory responses)
// slave : stack_controller
//   op_valid/op_ready/op_code/push_data  operation request handshake
//   load_sp/load_sp_val                  direct SP load
//   pull_data/done/err                   operation result
//   sp/level                             stack pointer and occupancy
//   sp_wr/sp_wr_data                     SP mirror strobe to register_file
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack  byte memory port
interface stack_controller_if;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_code;
    logic [15:0] push_data;
    logic        load_sp;
    logic [7:0]  load_sp_val;
    logic [15:0] pull_data;
    logic        done;
    logic        err;
    logic [7:0]  sp;
    logic [8:0]  level;
    logic        sp_wr;
    logic [7:0]  sp_wr_data;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport master (
        output op_valid, op_code, push_data, load_sp, load_sp_val, mem_rdata, mem_ack,
        input  op_ready, pull_data, done, err, sp, level, sp_wr, sp_wr_data,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  op_valid, op_code, push_data, load_sp, load_sp_val, mem_rdata, mem_ack,
        output op_ready, pull_data, done, err, sp, level, sp_wr, sp_wr_data,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/stack_controller.sv
// rtl/stack_controller.sv - byte-serial 8/16-bit push/pull sequencer owning the CPU stack pointer
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-high reset
//   bus    stack_controller_if.slave: op request, SP load, results, SP mirror, memory port
//
// The stack lives in page STACK_PAGE and grows downward. Push writes at sp then
// decrements; pull increments then reads. level counts bytes held (0..256) and is
// what keeps every access inside the page.
module stack_controller #(
    parameter logic [7:0] STACK_PAGE = 8'h01,
    parameter logic [7:0] SP_RESET   = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    stack_controller_if.slave  bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PUSH_HI = 3'd1;
    localparam logic [2:0] S_PUSH_LO = 3'd2;
    localparam logic [2:0] S_PULL_LO = 3'd3;
    localparam logic [2:0] S_PULL_HI = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;

    localparam logic [1:0] OP_PUSH8  = 2'b00;
    localparam logic [1:0] OP_PULL8  = 2'b01;
    localparam logic [1:0] OP_PUSH16 = 2'b10;

    logic [2:0]  state;
    logic [7:0]  sp;
    logic [8:0]  level;
    logic        is16;
    logic [7:0]  hold_byte;   // low push byte waiting its turn, or first pulled byte
    logic [15:0] pull_data;
    logic        done;
    logic        err;
    logic        sp_wr;
    logic [7:0]  sp_wr_data;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;

    logic        accept;
    logic        ack;
    logic        bound_err;
    logic [7:0]  sp_dec;
    logic [7:0]  sp_inc;
    logic [7:0]  sp_inc2;

    assign bus.op_ready   = (state == S_IDLE) && !bus.load_sp && !reset;
    assign bus.pull_data  = pull_data;
    assign bus.done       = done;
    assign bus.err        = err;
    assign bus.sp         = sp;
    assign bus.level      = level;
    assign bus.sp_wr      = sp_wr;
    assign bus.sp_wr_data = sp_wr_data;
    assign bus.mem_req    = mem_req;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;

    assign accept  = bus.op_valid && bus.op_ready;
    // mem_req is only raised in the four memory states, so an ack seen
    // in IDLE or FINISH never qualifies.
    assign ack     = mem_req && bus.mem_ack;
    assign sp_dec  = sp - 8'd1;
    assign sp_inc  = sp + 8'd1;
    assign sp_inc2 = sp + 8'd2;

    always_comb begin
        bound_err = 1'b0;
        case (bus.op_code)
            OP_PUSH8:  bound_err = (level == 9'd256);
            OP_PULL8:  bound_err = (level == 9'd0);
            OP_PUSH16: bound_err = (level > 9'd254);
            default:   bound_err = (level < 9'd2);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            sp         <= SP_RESET;
            level      <= 9'd0;
            is16       <= 1'b0;
            hold_byte  <= 8'h00;
            pull_data  <= 16'h0000;
            done       <= 1'b0;
            err        <= 1'b0;
            sp_wr      <= 1'b0;
            sp_wr_data <= SP_RESET;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 8'h00;
        end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            sp_wr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.load_sp) begin
                        sp         <= bus.load_sp_val;
                        level      <= {1'b0, SP_RESET - bus.load_sp_val};
                        sp_wr      <= 1'b1;
                        sp_wr_data <= bus.load_sp_val;
                    end else if (accept) begin
                        is16      <= bus.op_code[1];
                        hold_byte <= bus.push_data[7:0];
                        if (bound_err) begin
                            state <= S_FINISH;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            mem_req <= 1'b1;
                            case (bus.op_code)
                                OP_PUSH8: begin
                                    state     <= S_PUSH_LO;
                                    mem_we    <= 1'b1;
                                    mem_addr  <= {STACK_PAGE, sp};
                                    mem_wdata <= bus.push_data[7:0];
                                end
                                OP_PUSH16: begin
                                    state     <= S_PUSH_HI;
                                    mem_we    <= 1'b1;
                                    mem_addr  <= {STACK_PAGE, sp};
                                    mem_wdata <= bus.push_data[15:8];
                                end
                                default: begin
                                    state    <= S_PULL_LO;
                                    mem_we   <= 1'b0;
                                    mem_addr <= {STACK_PAGE, sp_inc};
                                end
                            endcase
                        end
                    end
                end
                S_PUSH_HI: begin
                    if (ack) begin
                        state     <= S_PUSH_LO;
                        sp        <= sp_dec;
                        level     <= level + 9'd1;
                        mem_addr  <= {STACK_PAGE, sp_dec};
                        mem_wdata <= hold_byte;
                    end
                end
                S_PUSH_LO: begin
                    if (ack) begin
                        state      <= S_FINISH;
                        sp         <= sp_dec;
                        level      <= level + 9'd1;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        done       <= 1'b1;
                        sp_wr      <= 1'b1;
                        sp_wr_data <= sp_dec;
                    end
                end
                S_PULL_LO: begin
                    if (ack) begin
                        sp    <= sp_inc;
                        level <= level - 9'd1;
                        if (is16) begin
                            state     <= S_PULL_HI;
                            hold_byte <= bus.mem_rdata;
                            mem_addr  <= {STACK_PAGE, sp_inc2};
                        end else begin
                            state      <= S_FINISH;
                            pull_data  <= {8'h00, bus.mem_rdata};
                            mem_req    <= 1'b0;
                            done       <= 1'b1;
                            sp_wr      <= 1'b1;
                            sp_wr_data <= sp_inc;
                        end
                    end
                end
                S_PULL_HI: begin
                    if (ack) begin
                        state      <= S_FINISH;
                        sp         <= sp_inc;
                        level      <= level - 9'd1;
                        pull_data  <= {bus.mem_rdata, hold_byte};
                        mem_req    <= 1'b0;
                        done       <= 1'b1;
                        sp_wr      <= 1'b1;
                        sp_wr_data <= sp_inc;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule
